// File: rtl/multi_digit_display_scan.sv
// Scanned driver for a NUM_DIGITS hex seven-segment display, tear-free frames.
// Define LEADING_ZERO_BLANK_EN to darken leading zero digits.
module multi_digit_display_scan #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic                    load_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic [NUM_DIGITS-1:0]   blank_i,
   input  logic                    enable_i,
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_o
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
   localparam logic [PW-1:0] TC   = PW'(REFRESH_DIV - 1);

   logic [PW-1:0] presc;
   logic [IW-1:0] idx;
   logic [W-1:0]  pending;
   logic [W-1:0]  shadow;
   logic          pend_v;
   logic          tick;
   logic          wrap;
   logic [3:0]    nib;
   logic          zblank;

   function automatic logic [6:0] glyph(input logic [3:0] h);
      case (h)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         4'hF: glyph = 7'h0E;
      endcase
   endfunction

   assign tick = enable_i && (presc == TC);
   assign wrap = tick && (idx == LAST);
   assign nib  = shadow[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] upper_zero;

   // upper_zero[k]: nibbles k..top of the shadow word are all zero
   always_comb begin
      upper_zero = '0;
      for (int k = 0; k < NUM_DIGITS; k++)
         upper_zero[k] = ((shadow >> (4 * k)) == '0);
   end

   assign zblank = (idx != '0) && upper_zero[idx];
`else
   assign zblank = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc   <= '0;
         idx     <= '0;
         pending <= '0;
         shadow  <= '0;
         pend_v  <= 1'b0;
         seg_o   <= 7'h7F;
         dp_o    <= 1'b1;
         an_o    <= '1;
         frame_o <= 1'b0;
      end else begin
         frame_o <= wrap;
         if (enable_i) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick)
               idx <= (idx == LAST) ? '0 : idx + IW'(1);
         end
         // a load coinciding with the boundary goes straight to the shadow
         if (wrap) begin
            if (load_i)
               shadow <= value_i;
            else if (pend_v)
               shadow <= pending;
            pend_v <= 1'b0;
         end else if (load_i) begin
            pending <= value_i;
            pend_v  <= 1'b1;
         end
         if (!enable_i) begin
            seg_o <= 7'h7F;
            dp_o  <= 1'b1;
            an_o  <= '1;
         end else begin
            an_o  <= ~(NUM_DIGITS'(1) << idx);
            seg_o <= (blank_i[idx] || zblank) ? 7'h7F : glyph(nib);
            dp_o  <= blank_i[idx] ? 1'b1 : ~dp_i[idx];
         end
      end
   end

endmodule
